// File: rtl/ws2812_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812_rx                                                        |
// | Brief    : WS2812 line decoder; pulse-width bit recovery into a pixel RAM  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ws2812_rx #(
  parameter logic [15:0] T_HIGH_MIN   = 16'd20,
  parameter logic [15:0] T_BIT_THRESH = 16'd120,
  parameter logic [15:0] T_HIGH_MAX   = 16'd400,
  parameter logic [15:0] T_RESET      = 16'd10000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        data_in,
  output logic        ram_wr_en_out,
  output logic [5:0]  ram_wr_addr_out,
  output logic [31:0] ram_wr_data_out,
  output logic        frame_done_out,
  output logic [6:0]  frame_len_out,
  output logic        bit_err_out
);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  localparam logic [4:0] C_LAST_BIT = 5'd23;
  localparam logic [6:0] C_MAX_PIX  = 7'd64;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_sync1;
  logic         r_sync2;
  logic         r_prev;

  logic [15:0]  r_hcnt;
  logic [15:0]  r_lcnt;
  logic [4:0]   r_bitcnt;
  logic [6:0]   r_pixcnt;
  logic         r_active;
  logic [23:0]  r_shreg;

  logic         r_wr_en;
  logic [5:0]   r_wr_addr;
  logic [31:0]  r_wr_data;
  logic         r_done;
  logic [6:0]   r_len;
  logic         r_err;

  logic [15:0]  w_hcnt_nxt;
  logic [15:0]  w_lcnt_nxt;
  logic [4:0]   w_bitcnt_nxt;
  logic [6:0]   w_pixcnt_nxt;
  logic         w_active_nxt;
  logic [23:0]  w_shreg_nxt;
  logic         w_wr_en_nxt;
  logic [5:0]   w_wr_addr_nxt;
  logic [31:0]  w_wr_data_nxt;
  logic         w_done_nxt;
  logic [6:0]   w_len_nxt;
  logic         w_err_nxt;

  logic         w_rise;
  logic         w_fall;
  logic         w_bit;
  logic [23:0]  w_shreg_shift;
  logic [16:0]  w_lcnt_inc;
  logic         w_lcnt_reach;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise        = r_sync2 & ~r_prev;
  assign w_fall        = ~r_sync2 & r_prev;
  assign w_bit         = (r_hcnt >= T_BIT_THRESH);
  assign w_shreg_shift = {r_shreg[22:0], w_bit};
  // One extra bit so the low counter compare cannot wrap near 16'hFFFF.
  assign w_lcnt_inc    = {1'b0, r_lcnt} + 17'd1;
  assign w_lcnt_reach  = (w_lcnt_inc >= {1'b0, T_RESET});

  always_comb begin
    w_state_nxt   = r_state;
    w_hcnt_nxt    = r_hcnt;
    w_lcnt_nxt    = r_lcnt;
    w_bitcnt_nxt  = r_bitcnt;
    w_pixcnt_nxt  = r_pixcnt;
    w_active_nxt  = r_active;
    w_shreg_nxt   = r_shreg;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_done_nxt    = 1'b0;
    w_len_nxt     = r_len;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_SYNC: begin
        if (r_sync2) begin
          w_lcnt_nxt = 16'd0;
        end else if (w_lcnt_reach) begin
          w_lcnt_nxt  = T_RESET;
          w_state_nxt = S_IDLE;
        end else begin
          w_lcnt_nxt = w_lcnt_inc[15:0];
        end
      end

      S_IDLE: begin
        if (w_rise) begin
          w_hcnt_nxt  = 16'd1;
          w_state_nxt = S_HIGH;
        end
      end

      S_HIGH: begin
        if (r_hcnt >= T_HIGH_MAX) begin
          // Line stuck high: abandon the frame and wait for a clean reset gap.
          w_err_nxt    = 1'b1;
          w_bitcnt_nxt = 5'd0;
          w_pixcnt_nxt = 7'd0;
          w_active_nxt = 1'b0;
          w_lcnt_nxt   = 16'd0;
          w_state_nxt  = S_SYNC;
        end else if (w_fall) begin
          w_lcnt_nxt = 16'd0;
          if (r_hcnt < T_HIGH_MIN) begin
            w_state_nxt = r_active ? S_LOW : S_IDLE;
          end else begin
            w_shreg_nxt  = w_shreg_shift;
            w_active_nxt = 1'b1;
            w_state_nxt  = S_LOW;
            if (r_bitcnt == C_LAST_BIT) begin
              w_bitcnt_nxt = 5'd0;
              if (r_pixcnt < C_MAX_PIX) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_pixcnt[5:0];
                w_wr_data_nxt = {8'h00, w_shreg_shift};
                w_pixcnt_nxt  = r_pixcnt + 7'd1;
              end
            end else begin
              w_bitcnt_nxt = r_bitcnt + 5'd1;
            end
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 16'd1;
        end
      end

      S_LOW: begin
        if (w_rise) begin
          w_hcnt_nxt  = 16'd1;
          w_state_nxt = S_HIGH;
        end else if (w_lcnt_reach) begin
          w_lcnt_nxt = T_RESET;
          w_err_nxt  = (r_bitcnt != 5'd0);
          if (r_active) begin
            w_done_nxt = 1'b1;
            w_len_nxt  = r_pixcnt;
          end
          w_pixcnt_nxt = 7'd0;
          w_bitcnt_nxt = 5'd0;
          w_active_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_lcnt_nxt = w_lcnt_inc[15:0];
        end
      end

      default: begin
        w_state_nxt = S_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= S_SYNC;
      r_hcnt    <= 16'd0;
      r_lcnt    <= 16'd0;
      r_bitcnt  <= 5'd0;
      r_pixcnt  <= 7'd0;
      r_active  <= 1'b0;
      r_shreg   <= 24'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 6'd0;
      r_wr_data <= 32'd0;
      r_done    <= 1'b0;
      r_len     <= 7'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_lcnt    <= w_lcnt_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_pixcnt  <= w_pixcnt_nxt;
      r_active  <= w_active_nxt;
      r_shreg   <= w_shreg_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_done    <= w_done_nxt;
      r_len     <= w_len_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign ram_wr_en_out   = r_wr_en;
  assign ram_wr_addr_out = r_wr_addr;
  assign ram_wr_data_out = r_wr_data;
  assign frame_done_out  = r_done;
  assign frame_len_out   = r_len;
  assign bit_err_out     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ws2812_rx                                                     |
// | Brief    : Randomized self-checking bench for ws2812_rx (scaled timings)   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ws2812_rx;

  localparam int I_MIN = 3;
  localparam int I_TH  = 7;
  localparam int I_MAX = 14;
  localparam int I_RST = 60;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        data_in;
  logic        ram_wr_en_out;
  logic [5:0]  ram_wr_addr_out;
  logic [31:0] ram_wr_data_out;
  logic        frame_done_out;
  logic [6:0]  frame_len_out;
  logic        bit_err_out;

  int checks = 0;
  int failures = 0;

  logic [37:0] obs_q[$];
  int n_done = 0;
  int n_err = 0;
  int n_err_with_done = 0;
  int n_wr_with_done = 0;

  ws2812_rx #(
    .T_HIGH_MIN  (16'(I_MIN)),
    .T_BIT_THRESH(16'(I_TH)),
    .T_HIGH_MAX  (16'(I_MAX)),
    .T_RESET     (16'(I_RST))
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .data_in        (data_in),
    .ram_wr_en_out  (ram_wr_en_out),
    .ram_wr_addr_out(ram_wr_addr_out),
    .ram_wr_data_out(ram_wr_data_out),
    .frame_done_out (frame_done_out),
    .frame_len_out  (frame_len_out),
    .bit_err_out    (bit_err_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1) begin
      if (ram_wr_en_out) obs_q.push_back({ram_wr_addr_out, ram_wr_data_out});
      if (frame_done_out) n_done++;
      if (bit_err_out) n_err++;
      if (bit_err_out && frame_done_out) n_err_with_done++;
      if (ram_wr_en_out && frame_done_out) n_wr_with_done++;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  // Reference decoding rule: a high pulse under the glitch floor is ignored,
  // otherwise it is a 1 exactly when it meets the threshold.
  function automatic bit is_glitch(input int w);
    return w < I_MIN;
  endfunction

  function automatic logic decode_width(input int w);
    return (w >= I_TH) ? 1'b1 : 1'b0;
  endfunction

  task automatic drive(input logic v, input int n);
    data_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_pulse(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    int w;
    w = b ? int'($urandom_range(I_MAX - 1, I_TH)) : int'($urandom_range(I_TH - 1, I_MIN));
    send_pulse(w, int'($urandom_range(6, 1)));
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic end_frame();
    drive(1'b0, I_RST + 10);
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    data_in  = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    data_in  = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if ({ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, frame_done_out, frame_len_out, bit_err_out} !== 48'd0) begin
      failures++;
      $display("FAIL reset_hold: got %h want 0",
               {ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, frame_done_out, frame_len_out, bit_err_out});
    end
    rst_n_in = 1'b1;
    drive(1'b0, 5);
    checks++;
    if ({ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, frame_done_out, frame_len_out, bit_err_out} !== 48'd0) begin
      failures++;
      $display("FAIL reset_release: got %h want 0",
               {ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, frame_done_out, frame_len_out, bit_err_out});
    end
  endtask

  task automatic test_mid_frame_start();
    int q0, d0, e0;
    logic [23:0] p;
    apply_reset();
    q0 = obs_q.size(); d0 = n_done; e0 = n_err;
    send_pixel(24'($urandom));
    send_pixel(24'($urandom));
    for (int i = 0; i < 7; i++) send_bit(1'($urandom));
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 0 || n_done - d0 != 0 || n_err - e0 != 0) begin
      failures++;
      $display("FAIL midstart_silent: got writes=%0d done=%0d err=%0d want 0/0/0",
               obs_q.size() - q0, n_done - d0, n_err - e0);
    end
    p = 24'($urandom);
    send_pixel(p);
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 1) begin
      failures++;
      $display("FAIL midstart_count: got %0d want 1", obs_q.size() - q0);
    end else if (obs_q[q0] !== {6'd0, 8'h00, p}) begin
      failures++;
      $display("FAIL midstart_count: got %h want %h", obs_q[q0], {6'd0, 8'h00, p});
    end
  endtask

  task automatic test_single_pixel();
    int q0, d0, e0;
    logic [23:0] p;
    p = 24'hA50F3C;
    q0 = obs_q.size(); d0 = n_done; e0 = n_err;
    for (int i = 23; i >= 0; i--) begin
      if (p[i]) send_pulse(8, 4);
      else      send_pulse(4, 8);
    end
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 1) begin
      failures++;
      $display("FAIL single_write_count: got %0d want 1", obs_q.size() - q0);
    end else begin
      checks++;
      if (obs_q[q0] !== {6'd0, 32'h00A50F3C}) begin
        failures++;
        $display("FAIL single_write_data: got %h want %h", obs_q[q0], {6'd0, 32'h00A50F3C});
      end
    end
    checks++;
    if (n_done - d0 != 1 || frame_len_out !== 7'd1 || n_err - e0 != 0) begin
      failures++;
      $display("FAIL single_frame: got done=%0d len=%0d err=%0d want 1/1/0",
               n_done - d0, frame_len_out, n_err - e0);
    end
  endtask

  task automatic test_full_overflow();
    int q0, d0;
    logic [23:0] px[66];
    q0 = obs_q.size(); d0 = n_done;
    for (int i = 0; i < 64; i++) send_pixel(24'(i));
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 64 || n_done - d0 != 1 || frame_len_out !== 7'd64) begin
      failures++;
      $display("FAIL full_frame: got writes=%0d done=%0d len=%0d want 64/1/64",
               obs_q.size() - q0, n_done - d0, frame_len_out);
    end
    for (int i = 0; i < 64; i++) begin
      if (obs_q.size() > q0 + i) begin
        checks++;
        if (obs_q[q0 + i] !== {6'(i), 8'h00, 24'(i)}) begin
          failures++;
          $display("FAIL full_entry_%0d: got %h want %h", i, obs_q[q0 + i], {6'(i), 8'h00, 24'(i)});
        end
      end
    end
    q0 = obs_q.size(); d0 = n_done;
    for (int i = 0; i < 66; i++) begin
      px[i] = 24'($urandom);
      send_pixel(px[i]);
    end
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 64 || n_done - d0 != 1 || frame_len_out !== 7'd64) begin
      failures++;
      $display("FAIL overflow_frame: got writes=%0d done=%0d len=%0d want 64/1/64",
               obs_q.size() - q0, n_done - d0, frame_len_out);
    end
    for (int i = 0; i < 64; i++) begin
      if (obs_q.size() > q0 + i) begin
        checks++;
        if (obs_q[q0 + i] !== {6'(i), 8'h00, px[i]}) begin
          failures++;
          $display("FAIL overflow_entry_%0d: got %h want %h", i, obs_q[q0 + i], {6'(i), 8'h00, px[i]});
        end
      end
    end
  endtask

  task automatic test_threshold_glitch();
    int q0, d0, e0, w;
    int choices[4];
    logic [23:0] expv;
    choices[0] = I_MIN; choices[1] = I_TH - 1; choices[2] = I_TH; choices[3] = I_MAX - 1;
    q0 = obs_q.size(); d0 = n_done; e0 = n_err;
    expv = 24'd0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      w = I_TH - 1;
      else if (i == 1) w = I_TH;
      else             w = choices[$urandom_range(3, 0)];
      if (!is_glitch(w)) expv = {expv[22:0], decode_width(w)};
      // A gap one cycle short of the reset time must not end the frame.
      send_pulse(w, (i == 5) ? I_RST - 1 : int'($urandom_range(6, 1)));
      if (i == 11) send_pulse(int'($urandom_range(I_MIN - 1, 1)), 3);
    end
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 1) begin
      failures++;
      $display("FAIL thresh_count: got %0d want 1", obs_q.size() - q0);
    end else begin
      checks++;
      if (obs_q[q0] !== {6'd0, 8'h00, expv}) begin
        failures++;
        $display("FAIL thresh_data: got %h want %h", obs_q[q0], {6'd0, 8'h00, expv});
      end
    end
    checks++;
    if (n_done - d0 != 1 || frame_len_out !== 7'd1 || n_err - e0 != 0) begin
      failures++;
      $display("FAIL thresh_frame: got done=%0d len=%0d err=%0d want 1/1/0",
               n_done - d0, frame_len_out, n_err - e0);
    end
  endtask

  task automatic test_stuck_high();
    int q0, d0, e0;
    logic [23:0] p;
    q0 = obs_q.size(); d0 = n_done; e0 = n_err;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    drive(1'b1, 2 * I_MAX + 5);
    end_frame();
    checks++;
    if (n_err - e0 != 1 || obs_q.size() - q0 != 0 || n_done - d0 != 0) begin
      failures++;
      $display("FAIL stuck_err: got err=%0d writes=%0d done=%0d want 1/0/0",
               n_err - e0, obs_q.size() - q0, n_done - d0);
    end
    p = 24'($urandom);
    send_pixel(p);
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 1) begin
      failures++;
      $display("FAIL stuck_recover: got writes=%0d want 1", obs_q.size() - q0);
    end else if (obs_q[q0] !== {6'd0, 8'h00, p} || frame_len_out !== 7'd1) begin
      failures++;
      $display("FAIL stuck_recover: got %h len=%0d want %h len=1", obs_q[q0], frame_len_out, {6'd0, 8'h00, p});
    end
  endtask

  task automatic test_partial();
    int q0, d0, e0, ed0;
    logic [23:0] px[2];
    q0 = obs_q.size(); d0 = n_done; e0 = n_err; ed0 = n_err_with_done;
    for (int i = 0; i < 2; i++) begin
      px[i] = 24'($urandom);
      send_pixel(px[i]);
    end
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    end_frame();
    checks++;
    if (obs_q.size() - q0 != 2 || n_done - d0 != 1 || n_err - e0 != 1 || n_err_with_done - ed0 != 1) begin
      failures++;
      $display("FAIL partial_frame: got writes=%0d done=%0d err=%0d together=%0d want 2/1/1/1",
               obs_q.size() - q0, n_done - d0, n_err - e0, n_err_with_done - ed0);
    end
    checks++;
    if (frame_len_out !== 7'd2) begin
      failures++;
      $display("FAIL partial_len: got %0d want 2", frame_len_out);
    end
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() > q0 + i) begin
        checks++;
        if (obs_q[q0 + i] !== {6'(i), 8'h00, px[i]}) begin
          failures++;
          $display("FAIL partial_entry_%0d: got %h want %h", i, obs_q[q0 + i], {6'(i), 8'h00, px[i]});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 20);
    checks++;
    if (frame_len_out !== 7'd2) begin
      failures++;
      $display("FAIL len_held: got %0d want 2", frame_len_out);
    end
    for (int i = 0; i < 9; i++) send_bit(1'($urandom));
    data_in = 1'b1;
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if ({ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, frame_done_out, frame_len_out, bit_err_out} !== 48'd0) begin
      failures++;
      $display("FAIL async_reset: got %h want 0",
               {ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, frame_done_out, frame_len_out, bit_err_out});
    end
    repeat (2) @(posedge clk_in);
    #1;
    data_in  = 1'b0;
    rst_n_in = 1'b1;
    drive(1'b0, 5);
  endtask

  initial begin
    rst_n_in = 1'b0;
    data_in  = 1'b0;
    test_reset();
    test_mid_frame_start();
    test_single_pixel();
    test_full_overflow();
    test_threshold_glitch();
    test_stuck_high();
    test_partial();
    test_async_reset();
    checks++;
    if (n_wr_with_done != 0) begin
      failures++;
      $display("FAIL write_with_done: got %0d want 0", n_wr_with_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws2812_rx.md
# ws2812_rx

Serial-line decoder for the WS2812/NeoPixel single-wire protocol. It recovers bits on the LED data line by measuring high-pulse width, assembles 24-bit pixel words MSB-first, and writes each word into a 64-entry pixel RAM. It also detects the end-of-frame low period. It sits at the line input of the controller and is used for loopback checking of the transmit path and for capturing frames from an upstream driver.

## Interface
Parameters, all in clk_in cycles; defaults assume a 200 MHz clock:
- T_HIGH_MIN, 16'd20: high pulses shorter than this are glitches and are discarded.
- T_BIT_THRESH, 16'd120: a high width at or above this decodes as 1; below it decodes as 0.
- T_HIGH_MAX, 16'd400: a high width reaching this is a line error.
- T_RESET, 16'd10000: a low period reaching this ends the frame (50 us).

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- data_in  in  1  asynchronous WS2812 serial line
- ram_wr_en_out  out  1  one-cycle pixel write strobe
- ram_wr_addr_out  out  6  pixel address
- ram_wr_data_out  out  32  {8'h00, 24-bit pixel in wire order}
- frame_done_out  out  1  one-cycle end-of-frame pulse
- frame_len_out  out  7  pixels written in the last frame (0..64), held between frames
- bit_err_out  out  1  one-cycle error pulse

## Operation
- Input path: data_in passes through a 2-FF synchronizer. Edges are detected against a third register.
- Counters:
  - hcnt counts the current high width and saturates at T_HIGH_MAX.
  - lcnt counts the current low width and saturates at T_RESET.
  - bitcnt is 5 bits, range 0..23.
  - pixcnt is 7 bits, range 0..64.
  - active flag: set once the frame has accepted at least one valid bit.
- S_SYNC (reset state): counts consecutive low cycles; any rising edge restarts the count. Reaching T_RESET moves to S_IDLE. This prevents decoding from mid-frame.
- S_IDLE: on a rising edge, go to S_HIGH with hcnt=1.
- S_HIGH, falling edge:
  - hcnt < T_HIGH_MIN: glitch. Discard it; go to S_LOW if active, otherwise S_IDLE.
  - Otherwise: bit = (hcnt >= T_BIT_THRESH). Shift the bit into shreg[23:0] from the LSB end, so the first bit lands at [23]. Set active, increment bitcnt, go to S_LOW with lcnt=0.
  - When bitcnt reaches 24: issue a write if pixcnt < 64. The write uses addr = pixcnt[5:0] and data = {8'h00, shreg}. Then pixcnt++ and bitcnt=0. If pixcnt is already 64, the pixel is dropped silently and pixcnt stays 64 (no wrap, no overwrite).
- S_HIGH, hcnt reaches T_HIGH_MAX while the line is still high:
  - Pulse bit_err_out and discard the partial pixel (bitcnt=0).
  - Pixels already written stay written; no frame_done_out.
  - Clear pixcnt and active, go to S_SYNC.
- S_LOW:
  - Rising edge: go to S_HIGH with hcnt=1.
  - lcnt reaches T_RESET: end of frame.
    - If bitcnt != 0, pulse bit_err_out in the same cycle and drop the partial pixel.
    - If active, pulse frame_done_out and load frame_len_out = pixcnt.
    - Clear pixcnt, bitcnt and active; go to S_IDLE.
- Reset values: all outputs 0, state S_SYNC, all counters 0.
- Asynchronous reset mid-frame aborts everything. Partially written RAM contents are not cleared.

## Timing
- Latency: a synchronized edge is seen 2–3 cycles after it occurs on data_in. Pulse widths are measured on the synchronized signal, so the latency cancels out of the width.
- Writes:
  - ram_wr_en_out is registered, high for exactly one cycle, in the cycle after the 24th falling edge is detected.
  - ram_wr_addr_out and ram_wr_data_out are valid in that cycle and held until the next write.
- frame_done_out fires in the cycle after lcnt reaches T_RESET, i.e. T_RESET+1 cycles after the last falling edge. frame_len_out updates in the same cycle.
- Boundary cases:
  - hcnt = T_BIT_THRESH-1 decodes as 0; hcnt = T_BIT_THRESH decodes as 1.
  - hcnt = T_HIGH_MIN is a valid bit.
  - A low gap of T_RESET-1 cycles does not end the frame.
- A write strobe and frame_done_out never occur in the same cycle: the write follows a falling edge, and frame end needs T_RESET low cycles.

## Test plan
- **Single pixel.** Reset, 10000 low cycles, then pixel 0xA50F3C (0: 80 high/170 low; 1: 160 high/90 low), then 10000 low. Required: one write with addr 0, data 0x00A50F3C; frame_done_out pulse; frame_len_out = 1; no bit_err_out.
- **Full and overflow frames.** 64 pixels with data = index. Required: addr 0..63 with matching data, frame_len_out = 64. Then a 66-pixel frame. Required: exactly 64 writes, frame_len_out = 64.
- **Threshold and glitch.** High widths of 119 and 120 decode as 0 and 1. A 10-cycle high pulse inserted mid-pixel is ignored, and the pixel still decodes correctly.
- **Stuck high.** Line held high for 500 cycles after 5 bits. Required: bit_err_out pulse, no write, no frame_done_out. After 10000 low cycles, the next pixel is written to addr 0.
- **Partial pixel.** 2 full pixels, then 12 bits, then 10000 low. Required: 2 writes, a bit_err_out pulse together with frame_done_out, frame_len_out = 2.
- **Mid-frame start and reset.** Bit traffic starting right after reset. Required: no writes until 10000 consecutive low cycles are seen. Asserting rst_n_in low mid-pixel forces all outputs to 0 immediately.
